// File: rtl/spi_cfg_tx.sv
// Serialises one 60-bit configuration word MSB first under an active-low nss
// frame of exactly 60 clk cycles, followed by a fixed nss-high gap.
module spi_cfg_tx #(
  parameter int GAP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  adsr_ai,
  input  logic [7:0]  adsr_di,
  input  logic [7:0]  adsr_s,
  input  logic [7:0]  adsr_ri,
  input  logic [11:0] osc_count,
  input  logic [7:0]  filter_a,
  input  logic [7:0]  filter_b,
  output logic        nss,
  output logic        mosi,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

  state_t      state, state_d;
  logic [59:0] word, word_d;
  logic [59:0] in_word;
  logic [5:0]  bit_cnt, bit_cnt_d;
  logic [7:0]  gap_cnt, gap_cnt_d;
  logic        nss_d, mosi_d, done_d, ready_d, busy_d;

  assign in_word = {filter_b, filter_a, osc_count, adsr_ri, adsr_s, adsr_di, adsr_ai};

  // Outputs are computed one edge ahead so the receiver, sampling on the same
  // edge, sees word[59] on the first edge after accept.
  always_comb begin
    state_d   = state;
    word_d    = word;
    bit_cnt_d = bit_cnt;
    gap_cnt_d = gap_cnt;
    nss_d     = 1'b1;
    mosi_d    = 1'b0;
    done_d    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d   = SHIFT;
          word_d    = in_word;
          bit_cnt_d = 6'd59;
          nss_d     = 1'b0;
          mosi_d    = in_word[59];
        end
      end
      SHIFT: begin
        if (bit_cnt == 6'd0) begin
          state_d   = GAP;
          gap_cnt_d = GAP_LOAD;
          done_d    = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt - 6'd1;
          nss_d     = 1'b0;
          mosi_d    = word[bit_cnt_d];
        end
      end
      GAP: begin
        if (gap_cnt == 8'd0) state_d = IDLE;
        else                 gap_cnt_d = gap_cnt - 8'd1;
      end
      default: state_d = IDLE;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      word     <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      nss      <= 1'b1;
      mosi     <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      word     <= word_d;
      bit_cnt  <= bit_cnt_d;
      gap_cnt  <= gap_cnt_d;
      nss      <= nss_d;
      mosi     <= mosi_d;
      in_ready <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

endmodule

// File: doc/spi_cfg_tx.md
# spi_cfg_tx

Serial configuration transmitter for the synth voice's SPI configuration port. It accepts one parallel configuration word through a valid/ready handshake and serialises it, MSB first, onto `mosi`. It frames the transfer with an active-low `nss` whose low time is exactly 60 `clk` cycles. It sits on the host/preset side of the link, drives the same `clk` as the on-chip config receiver, and guarantees the receiver's shift register ends up holding exactly the word presented.

## Interface
Parameters:
- `GAP_CYCLES`, default 4: number of `nss`-high cycles inserted after each frame before the next word is accepted. Legal range 1..255.

Ports:
- `clk` in 1: single system clock. The receiver samples `mosi` on the same edge.
- `rstn` in 1: synchronous, active-low reset.
- `in_valid` in 1: a configuration word is presented.
- `in_ready` out 1: the block can accept a word this cycle.
- `adsr_ai` in 8: packed into frame bits [7:0].
- `adsr_di` in 8: packed into frame bits [15:8].
- `adsr_s` in 8: packed into frame bits [23:16].
- `adsr_ri` in 8: packed into frame bits [31:24].
- `osc_count` in 12: packed into frame bits [43:32].
- `filter_a` in 8: packed into frame bits [51:44].
- `filter_b` in 8: packed into frame bits [59:52].
- `nss` out 1: frame select, active low. The receiver mutes the voice while it is low.
- `mosi` out 1: serial data.
- `busy` out 1: high from the accept cycle until the block returns to IDLE.
- `done` out 1: one-cycle pulse on the first `nss`-high cycle after a complete frame.

## Operation
- All outputs are registered. The word is latched on the accept cycle, so the fields may change afterwards without effect.
- States:
  - IDLE: `in_ready`=1, `nss`=1, `mosi`=0. When `in_valid`=1, latch the 60-bit word, load the bit counter with 59, and go to SHIFT.
  - SHIFT: `nss`=0, `mosi` = word[bit counter]. The counter decrements every cycle. When the counter is 0, go to GAP.
  - GAP: `nss`=1, `mosi`=0. Remain for GAP_CYCLES cycles, then go to IDLE. `done`=1 on the first GAP cycle only.
- Frame length is fixed at exactly 60 low cycles. The receiver shifts on every low cycle, so one extra or missing low cycle corrupts every field. No early termination is permitted.
- Bit order: the first bit sent is word[59] (`filter_b[7]`) and the last is word[0] (`adsr_ai[0]`). After the frame, the receiver register equals the word.
- `in_valid` during SHIFT or GAP is ignored and nothing is queued. The source must hold `in_valid` until it sees `in_ready`.
- Reset (`rstn`=0 at an edge) forces IDLE on that edge from any state. It also sets `nss`=1, `mosi`=0, `in_ready`=0, `busy`=0, `done`=0 and clears the latched word and counters.
  - `in_ready` rises on the first edge with `rstn`=1.
  - Reset mid-SHIFT aborts the frame. The receiver keeps a partial shift and the host must resend. This is accepted behaviour.

## Timing
- Accept on edge E (`in_valid` & `in_ready`).
- `nss` is low for edges E+1 through E+60. On edge E+k, `mosi` = word[60-k].
- `busy` is high from E+1 through E+60+GAP_CYCLES.
- `done` is high for edge E+61 only.
- `in_ready` is high again at edge E+61+GAP_CYCLES. With `in_valid` held, the next frame's first low cycle is E+62+GAP_CYCLES.
- Minimum `nss`-high time between back-to-back frames: GAP_CYCLES+1 cycles. Minimum accept-to-accept period: 61+GAP_CYCLES cycles.
- No combinational path from inputs to outputs.

## Test plan
- Single frame, loopback to a 60-bit receiver model: `adsr_ai`=8'h11, `adsr_di`=8'h22, `adsr_s`=8'h33, `adsr_ri`=8'h44, `osc_count`=12'hABC, `filter_a`=8'h5A, `filter_b`=8'hC3 → `nss` low for exactly 60 cycles, first `mosi` bit 1, the model reads back 60'hC35AABC44332211, and `done` pulses once at E+61.
- Back-to-back frames with `in_valid` held and GAP_CYCLES=4: words A then B → `nss` high for exactly 5 cycles between frames, and the model holds B at the end.
- Source changes the fields and toggles `in_valid` during SHIFT → transmitted bits match the word latched at accept, and no extra frame is sent.
- Reset asserted at the 30th low cycle → `nss`=1 on the next edge, `in_ready`=0 while `rstn`=0, `in_ready`=1 one edge after release, and no `done` pulse.
- All-zeros and all-ones words → `mosi` constant during the frame, `nss` low for 60 cycles, and `mosi`=0 in GAP.
- GAP_CYCLES=1 → accept-to-accept period is 62 cycles and `nss` high time is 2 cycles.
